// File: rtl/vip_axi4_burst_addr_gen_if.sv
// Command/beat bus of the AXI4 burst address generator. The slave modport is the
// generator side; the master modport is the side that issues commands and drains beats.
interface vip_axi4_burst_addr_gen_if #(
  parameter int ADDR_WIDTH_P = 32,
  parameter int DATA_WIDTH_P = 32,
  parameter int ID_WIDTH_P   = 4
) ();
  localparam int DATA_BYTES_C = DATA_WIDTH_P / 8;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [ADDR_WIDTH_P-1:0] cmd_addr;
  logic [7:0]              cmd_len;
  logic [2:0]              cmd_size;
  logic [1:0]              cmd_burst;
  logic [ID_WIDTH_P-1:0]   cmd_id;

  logic                    beat_valid;
  logic                    beat_ready;
  logic [ADDR_WIDTH_P-1:0] beat_addr;
  logic [DATA_BYTES_C-1:0] beat_strb;
  logic [ID_WIDTH_P-1:0]   beat_id;
  logic [7:0]              beat_index;
  logic                    beat_last;
  logic [1:0]              beat_resp;
  logic                    busy;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_id, beat_ready,
    output cmd_ready, beat_valid, beat_addr, beat_strb, beat_id, beat_index,
           beat_last, beat_resp, busy
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_id, beat_ready,
    input  cmd_ready, beat_valid, beat_addr, beat_strb, beat_id, beat_index,
           beat_last, beat_resp, busy
  );
endinterface

// File: rtl/vip_axi4_burst_addr_gen.sv
// Expands one AXI4 AW/AR command into per-beat address, strobe, index, last and
// response, handling FIXED/INCR/WRAP, narrow/unaligned transfers and 4 KB checks.
module vip_axi4_burst_addr_gen #(
  parameter int ADDR_WIDTH_P = 32,
  parameter int DATA_WIDTH_P = 32,
  parameter int ID_WIDTH_P   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  vip_axi4_burst_addr_gen_if.slave    bus
);
  localparam int DATA_BYTES_C = DATA_WIDTH_P / 8;
  localparam int WIDE_W_C     = ADDR_WIDTH_P + 16;

  localparam logic [ADDR_WIDTH_P-1:0] ONE_C       = ADDR_WIDTH_P'(1);
  localparam logic [ADDR_WIDTH_P-1:0] LANE_MASK_C = ADDR_WIDTH_P'(DATA_BYTES_C - 1);
  localparam logic [1:0]              RESP_OKAY   = 2'b00;
  localparam logic [1:0]              RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic {ST_IDLE, ST_BEAT} state_e;

  function automatic logic [ADDR_WIDTH_P-1:0] size_bytes(input logic [2:0] size);
    return ONE_C << size;
  endfunction

  function automatic logic [ADDR_WIDTH_P-1:0] align_addr(input logic [ADDR_WIDTH_P-1:0] addr,
                                                         input logic [2:0] size);
    return addr & ~(size_bytes(size) - ONE_C);
  endfunction

  // Lanes lo..hi; a transfer wider than the bus lights every lane.
  function automatic logic [DATA_BYTES_C-1:0] lane_strb(input logic [ADDR_WIDTH_P-1:0] addr,
                                                        input logic [2:0] size);
    logic [ADDR_WIDTH_P-1:0] bytes_v;
    logic [ADDR_WIDTH_P-1:0] lo_v;
    logic [ADDR_WIDTH_P-1:0] hi_v;
    logic [DATA_BYTES_C-1:0] strb_v;
    bytes_v = size_bytes(size);
    lo_v    = addr & LANE_MASK_C;
    hi_v    = (align_addr(addr, size) & LANE_MASK_C) + bytes_v - ONE_C;
    for (int i = 0; i < DATA_BYTES_C; i++) begin
      strb_v[i] = (ADDR_WIDTH_P'(i) >= lo_v) && (ADDR_WIDTH_P'(i) <= hi_v);
    end
    if (bytes_v > ADDR_WIDTH_P'(DATA_BYTES_C)) begin
      strb_v = '1;
    end
    return strb_v;
  endfunction

  function automatic logic [ADDR_WIDTH_P-1:0] next_addr(input logic [ADDR_WIDTH_P-1:0] cur,
                                                        input logic [2:0]              size,
                                                        input burst_e                  burst,
                                                        input logic [ADDR_WIDTH_P-1:0] lower,
                                                        input logic [ADDR_WIDTH_P-1:0] wend);
    logic [ADDR_WIDTH_P-1:0] inc_v;
    inc_v = align_addr(cur, size) + size_bytes(size);
    case (burst)
      BURST_FIXED: return cur;
      BURST_WRAP:  return (inc_v == wend) ? lower : inc_v;
      default:     return inc_v;
    endcase
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH_P-1:0] addr_q, addr_d;
  logic [DATA_BYTES_C-1:0] strb_q, strb_d;
  logic [ID_WIDTH_P-1:0]   id_q, id_d;
  logic [7:0]              index_q, index_d;
  logic                    last_q, last_d;
  logic [1:0]              resp_q, resp_d;
  logic [7:0]              len_q, len_d;
  logic [2:0]              size_q, size_d;
  burst_e                  burst_q, burst_d;
  logic [ADDR_WIDTH_P-1:0] wrap_lower_q, wrap_lower_d;
  logic [ADDR_WIDTH_P-1:0] wrap_end_q, wrap_end_d;

  logic                    beat_valid;
  logic                    beat_fire;
  logic                    cmd_ready;
  logic                    cmd_fire;
  logic [ADDR_WIDTH_P-1:0] cmd_bytes;
  logic [ADDR_WIDTH_P-1:0] cmd_aligned;
  logic [8:0]              cmd_len_p1;
  logic [WIDE_W_C-1:0]     wrap_total_w;
  logic [ADDR_WIDTH_P-1:0] cmd_wrap_lower;
  logic [31:0]             incr_span_end;
  logic                    err_rsvd, err_size, err_wrap, err_4k, err_fixed;
  burst_e                  cmd_burst_eff;
  logic [ADDR_WIDTH_P-1:0] addr_nxt;

  assign beat_valid = (state_q == ST_BEAT);
  assign beat_fire  = beat_valid && bus.beat_ready;
  assign cmd_ready  = (state_q == ST_IDLE) || (beat_fire && last_q);
  assign cmd_fire   = bus.cmd_valid && cmd_ready;

  // Command decode and legality checks, evaluated on the incoming command
  assign cmd_bytes      = size_bytes(bus.cmd_size);
  assign cmd_aligned    = align_addr(bus.cmd_addr, bus.cmd_size);
  assign cmd_len_p1     = {1'b0, bus.cmd_len} + 9'd1;
  assign wrap_total_w   = WIDE_W_C'(cmd_len_p1) << bus.cmd_size;
  assign cmd_wrap_lower = bus.cmd_addr & ~ADDR_WIDTH_P'(wrap_total_w - WIDE_W_C'(1));
  assign incr_span_end  = 32'(cmd_aligned[11:0]) + (32'(cmd_len_p1) << bus.cmd_size);
  assign cmd_burst_eff  = (bus.cmd_burst == BURST_RSVD) ? BURST_INCR : burst_e'(bus.cmd_burst);

  assign err_rsvd  = (bus.cmd_burst == BURST_RSVD);
  assign err_size  = (cmd_bytes > ADDR_WIDTH_P'(DATA_BYTES_C));
  assign err_wrap  = (bus.cmd_burst == BURST_WRAP) &&
                     (!(bus.cmd_len == 8'd1 || bus.cmd_len == 8'd3 ||
                        bus.cmd_len == 8'd7 || bus.cmd_len == 8'd15) ||
                      (bus.cmd_addr != cmd_aligned));
  assign err_4k    = (bus.cmd_burst == BURST_INCR) && (incr_span_end > 32'd4096);
  assign err_fixed = (bus.cmd_burst == BURST_FIXED) && (bus.cmd_len > 8'd15);

  assign addr_nxt = next_addr(addr_q, size_q, burst_q, wrap_lower_q, wrap_end_q);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    strb_d       = strb_q;
    id_d         = id_q;
    index_d      = index_q;
    last_d       = last_q;
    resp_d       = resp_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    wrap_lower_d = wrap_lower_q;
    wrap_end_d   = wrap_end_q;

    if (cmd_fire) begin
      // Also covers the last-beat cycle, so a queued command follows with no bubble
      state_d      = ST_BEAT;
      addr_d       = bus.cmd_addr;
      strb_d       = lane_strb(bus.cmd_addr, bus.cmd_size);
      id_d         = bus.cmd_id;
      index_d      = 8'd0;
      last_d       = (bus.cmd_len == 8'd0);
      resp_d       = (err_rsvd || err_size || err_wrap || err_4k || err_fixed) ?
                     RESP_SLVERR : RESP_OKAY;
      len_d        = bus.cmd_len;
      size_d       = bus.cmd_size;
      burst_d      = cmd_burst_eff;
      wrap_lower_d = cmd_wrap_lower;
      wrap_end_d   = cmd_wrap_lower + ADDR_WIDTH_P'(wrap_total_w);
    end else if (beat_fire) begin
      if (last_q) begin
        state_d = ST_IDLE;
      end else begin
        addr_d  = addr_nxt;
        strb_d  = lane_strb(addr_nxt, size_q);
        index_d = index_q + 8'd1;
        last_d  = ((index_q + 8'd1) == len_q);
      end
    end
  end

  // Beat output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      strb_q       <= '0;
      id_q         <= '0;
      index_q      <= '0;
      last_q       <= 1'b0;
      resp_q       <= RESP_OKAY;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= BURST_FIXED;
      wrap_lower_q <= '0;
      wrap_end_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      strb_q       <= strb_d;
      id_q         <= id_d;
      index_q      <= index_d;
      last_q       <= last_d;
      resp_q       <= resp_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      wrap_lower_q <= wrap_lower_d;
      wrap_end_q   <= wrap_end_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.beat_valid = beat_valid;
  assign bus.beat_addr  = addr_q;
  assign bus.beat_strb  = strb_q;
  assign bus.beat_id    = id_q;
  assign bus.beat_index = index_q;
  assign bus.beat_last  = last_q;
  assign bus.beat_resp  = resp_q;
  assign bus.busy       = (state_q == ST_BEAT);
endmodule

// File: tb/tb_vip_axi4_burst_addr_gen.sv
// Directed bench for vip_axi4_burst_addr_gen: expected beats are queued as each
// command is issued and compared as the generator hands them over.
module tb_vip_axi4_burst_addr_gen;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [7:0]  idx;
    logic        last;
    logic [1:0]  resp;
    logic [3:0]  id;
  } beat_t;

  logic  clk;
  logic  rst_n;
  beat_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  vip_axi4_burst_addr_gen_if #(.ADDR_WIDTH_P(32), .DATA_WIDTH_P(32), .ID_WIDTH_P(4)) bus_if ();

  vip_axi4_burst_addr_gen #(.ADDR_WIDTH_P(32), .DATA_WIDTH_P(32), .ID_WIDTH_P(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] addr, input logic [3:0] strb, input logic [7:0] idx,
                      input logic last, input logic [1:0] resp, input logic [3:0] id);
    beat_t b;
    b.addr = addr; b.strb = strb; b.idx = idx; b.last = last; b.resp = resp; b.id = id;
    sb_q.push_back(b);
  endtask

  // Called at a negedge: if a beat handshake is pending, check it against the queue head.
  task automatic sample_beat();
    beat_t e;
    if (bus_if.beat_valid && bus_if.beat_ready) begin
      chk("sb_has_expected", 64'(sb_q.size() != 0), 64'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("beat_addr", 64'(bus_if.beat_addr), 64'(e.addr));
        chk("beat_strb", 64'(bus_if.beat_strb), 64'(e.strb));
        chk("beat_idx_last_resp_id",
            64'({bus_if.beat_index, bus_if.beat_last, bus_if.beat_resp, bus_if.beat_id}),
            64'({e.idx, e.last, e.resp, e.id}));
      end
    end
  endtask

  task automatic send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                      input logic [1:0] burst, input logic [3:0] id);
    int n;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_len   = len;
    bus_if.cmd_size  = size;
    bus_if.cmd_burst = burst;
    bus_if.cmd_id    = id;
    bus_if.cmd_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      sample_beat();
      if (bus_if.cmd_ready) break;
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        chk("cmd_accept_timeout", 64'(bus_if.cmd_ready), 64'(1));
        break;
      end
    end
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    @(negedge clk);
    chk("accept_latency_valid_busy", 64'({bus_if.beat_valid, bus_if.busy}), 64'(2'b11));
    sample_beat();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      sample_beat();
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", 64'(sb_q.size()), 64'(0));
    @(negedge clk);
    chk("idle_after_burst", 64'({bus_if.busy, bus_if.beat_valid}), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus_if.cmd_valid  = 1'b0;
    bus_if.cmd_addr   = '0;
    bus_if.cmd_len    = '0;
    bus_if.cmd_size   = '0;
    bus_if.cmd_burst  = '0;
    bus_if.cmd_id     = '0;
    bus_if.beat_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_busy_last", 64'({bus_if.beat_valid, bus_if.busy, bus_if.beat_last}), 64'(0));
    chk("rst_addr", 64'(bus_if.beat_addr), 64'(0));
    chk("rst_strb_id_idx_resp",
        64'({bus_if.beat_strb, bus_if.beat_id, bus_if.beat_index, bus_if.beat_resp}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", 64'(bus_if.cmd_ready), 64'(1));
    @(posedge clk); #1;
    bus_if.beat_ready = 1'b1;

    // INCR unaligned start
    push(32'h1002, 4'b1100, 8'd0, 1'b0, OKAY, 4'd1);
    push(32'h1004, 4'b1111, 8'd1, 1'b0, OKAY, 4'd1);
    push(32'h1008, 4'b1111, 8'd2, 1'b0, OKAY, 4'd1);
    push(32'h100C, 4'b1111, 8'd3, 1'b1, OKAY, 4'd1);
    send(32'h1002, 8'd3, 3'd2, INCR, 4'd1);
    drain();

    // WRAP legal, then WRAP with illegal length
    push(32'h34, 4'hF, 8'd0, 1'b0, OKAY, 4'd2);
    push(32'h38, 4'hF, 8'd1, 1'b0, OKAY, 4'd2);
    push(32'h3C, 4'hF, 8'd2, 1'b0, OKAY, 4'd2);
    push(32'h30, 4'hF, 8'd3, 1'b1, OKAY, 4'd2);
    send(32'h34, 8'd3, 3'd2, WRAP, 4'd2);
    drain();
    push(32'h30, 4'hF, 8'd0, 1'b0, SLVERR, 4'd3);
    push(32'h34, 4'hF, 8'd1, 1'b0, SLVERR, 4'd3);
    push(32'h38, 4'hF, 8'd2, 1'b1, SLVERR, 4'd3);
    send(32'h30, 8'd2, 3'd2, WRAP, 4'd3);
    drain();

    // FIXED narrow, then INCR halfword unaligned
    for (int i = 0; i < 3; i++) push(32'h101, 4'b0010, 8'(i), (i == 2), OKAY, 4'd4);
    send(32'h101, 8'd2, 3'd0, FIXED, 4'd4);
    drain();
    push(32'h102, 4'b1100, 8'd0, 1'b0, OKAY, 4'd5);
    push(32'h104, 4'b0011, 8'd1, 1'b1, OKAY, 4'd5);
    send(32'h102, 8'd1, 3'd1, INCR, 4'd5);
    drain();

    // Error cases: 4 KB crossing, oversize, reserved burst, long FIXED
    push(32'hFF8,  4'hF, 8'd0, 1'b0, SLVERR, 4'd6);
    push(32'hFFC,  4'hF, 8'd1, 1'b0, SLVERR, 4'd6);
    push(32'h1000, 4'hF, 8'd2, 1'b0, SLVERR, 4'd6);
    push(32'h1004, 4'hF, 8'd3, 1'b1, SLVERR, 4'd6);
    send(32'hFF8, 8'd3, 3'd2, INCR, 4'd6);
    drain();
    push(32'h200, 4'hF, 8'd0, 1'b0, SLVERR, 4'd7);
    push(32'h208, 4'hF, 8'd1, 1'b1, SLVERR, 4'd7);
    send(32'h200, 8'd1, 3'd3, INCR, 4'd7);
    drain();
    push(32'h40, 4'hF, 8'd0, 1'b0, SLVERR, 4'd8);
    push(32'h44, 4'hF, 8'd1, 1'b1, SLVERR, 4'd8);
    send(32'h40, 8'd1, 3'd2, RSVD, 4'd8);
    drain();
    for (int i = 0; i < 17; i++) push(32'h10, 4'hF, 8'(i), (i == 16), SLVERR, 4'd9);
    send(32'h10, 8'd16, 3'd2, FIXED, 4'd9);
    drain();

    // Backpressure at index 1
    for (int i = 0; i < 4; i++) push(32'h500 + 32'(4 * i), 4'hF, 8'(i), (i == 3), OKAY, 4'd10);
    send(32'h500, 8'd3, 3'd2, INCR, 4'd10);
    bus_if.beat_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_addr", 64'(bus_if.beat_addr), 64'h504);
      chk("stall_valid_idx_strb_last",
          64'({bus_if.beat_valid, bus_if.beat_index, bus_if.beat_strb, bus_if.beat_last}),
          64'({1'b1, 8'd1, 4'hF, 1'b0}));
      @(posedge clk); #1;
    end
    bus_if.beat_ready = 1'b1;
    drain();

    // Back-to-back commands: no bubble between bursts
    push(32'h600, 4'hF, 8'd0, 1'b0, OKAY, 4'd6);
    push(32'h604, 4'hF, 8'd1, 1'b1, OKAY, 4'd6);
    send(32'h600, 8'd1, 3'd2, INCR, 4'd6);
    push(32'h700, 4'hF, 8'd0, 1'b0, OKAY, 4'd7);
    push(32'h704, 4'hF, 8'd1, 1'b1, OKAY, 4'd7);
    bus_if.beat_ready = 1'b0;
    bus_if.cmd_addr   = 32'h700;
    bus_if.cmd_len    = 8'd1;
    bus_if.cmd_size   = 3'd2;
    bus_if.cmd_burst  = INCR;
    bus_if.cmd_id     = 4'd7;
    bus_if.cmd_valid  = 1'b1;
    @(negedge clk);
    chk("b2b_ready_while_last_stalled", 64'(bus_if.cmd_ready), 64'(0));
    sample_beat();
    @(posedge clk); #1;
    bus_if.beat_ready = 1'b1;
    @(negedge clk);
    chk("b2b_ready_in_last_handshake", 64'(bus_if.cmd_ready), 64'(1));
    sample_beat();
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_no_gap_valid_idx", 64'({bus_if.beat_valid, bus_if.beat_index}), 64'({1'b1, 8'd0}));
    sample_beat();
    @(posedge clk); #1;
    drain();

    // Reset in the middle of a len 7 burst
    push(32'h800, 4'hF, 8'd0, 1'b0, OKAY, 4'd11);
    push(32'h804, 4'hF, 8'd1, 1'b0, OKAY, 4'd11);
    send(32'h800, 8'd7, 3'd2, INCR, 4'd11);
    @(negedge clk);
    sample_beat();
    @(posedge clk); #1;
    chk("pre_reset_index", 64'(bus_if.beat_index), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid_busy", 64'({bus_if.beat_valid, bus_if.busy}), 64'(0));
    chk("async_reset_addr_idx", 64'({bus_if.beat_addr, bus_if.beat_index}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("sb_empty_after_abort", 64'(sb_q.size()), 64'(0));
    @(negedge clk);
    chk("post_reset_ready_valid", 64'({bus_if.cmd_ready, bus_if.beat_valid}), 64'(2'b10));
    @(posedge clk); #1;
    push(32'h900, 4'hF, 8'd0, 1'b1, OKAY, 4'd12);
    send(32'h900, 8'd0, 3'd2, INCR, 4'd12);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vip_axi4_burst_addr_gen.md
Name: vip_axi4_burst_addr_gen

Overview:
- Parametrised AXI4 burst address/strobe generator for the VIP slave memory model and the DUT-side AXI4 slave front-ends.
- Accepts one AW or AR command per handshake and expands it into per-beat address, byte-lane strobe, beat index and last flag, using a valid/ready stream.
- Handles FIXED, INCR and WRAP bursts, narrow and unaligned transfers, and 4 KB boundary checks.
- Illegal commands are flagged per beat with an error response code instead of being dropped.

Parameters:
ADDR_WIDTH_P, 32, command and beat address width (12..64)
DATA_WIDTH_P, 32, bus data width in bits; power of two, 8..1024
ID_WIDTH_P, 4, transaction ID width
DATA_BYTES_C (derived), DATA_WIDTH_P/8, number of byte lanes

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_addr  in  ADDR_WIDTH_P  start address
cmd_len  in  8  AxLEN (beats-1)
cmd_size  in  3  AxSIZE encoding
cmd_burst  in  2  AxBURST encoding
cmd_id  in  ID_WIDTH_P  AxID
beat_valid  out  1  beat valid
beat_ready  in  1  beat ready
beat_addr  out  ADDR_WIDTH_P  beat address
beat_strb  out  DATA_BYTES_C  active byte lanes
beat_id  out  ID_WIDTH_P  registered cmd_id
beat_index  out  8  beat number, 0..len
beat_last  out  1  final beat of burst
beat_resp  out  2  00 OKAY or 10 SLVERR, constant over the burst
busy  out  1  burst in progress

Behaviour:
- Single clock domain. rst_n is asynchronous and active-low.
- Reset values: beat_valid=0, beat_addr=0, beat_strb=0, beat_id=0, beat_index=0, beat_last=0, beat_resp=00, busy=0. State is IDLE.
- FSM has two states: IDLE and BEAT.
  - IDLE: cmd_ready=1. A cmd_valid&cmd_ready handshake registers the command and moves to BEAT. beat_valid=1 on the next cycle, so there is 1 cycle latency.
  - BEAT: beat_valid=1. A beat_valid&beat_ready handshake advances beat_index and beat_addr. On the handshake of the last beat (beat_index==cmd_len), go to IDLE, unless a new command is accepted in the same cycle.
- cmd_ready = IDLE || (beat_valid && beat_ready && beat_last). This gives back-to-back bursts with no bubble. beat 0 of the new command appears on the following cycle.
- Outputs are registered and held stable while beat_valid && !beat_ready.
- busy = (state==BEAT).
- Arithmetic:
  - bytes = 1<<cmd_size.
  - aligned(a) = a & ~(bytes-1).
  - Beat 0 address = cmd_addr, which may be unaligned.
  - FIXED: every beat uses cmd_addr.
  - INCR: beat n>0 address = aligned(cmd_addr) + n*bytes, computed modulo 2^ADDR_WIDTH_P.
  - WRAP: total = bytes*(len+1); lower = cmd_addr & ~(total-1). After an increment, the next address is lower when it equals lower+total.
- Strobe:
  - lo = beat_addr mod DATA_BYTES_C.
  - hi = (aligned(beat_addr) mod DATA_BYTES_C) + bytes - 1.
  - beat_strb bits lo..hi are 1 and all others 0.
- Error checks run on command accept. Any failure sets beat_resp=SLVERR for every beat of that burst; addresses and strobes are still generated per the rules above. The checks are:
  - cmd_burst==11 (reserved). Treat the burst as INCR for addressing.
  - bytes > DATA_BYTES_C. Strobe becomes all-ones.
  - WRAP with len+1 not in {2,4,8,16}, or cmd_addr not aligned to bytes.
  - INCR where aligned(cmd_addr)[11:0] + (len+1)*bytes > 4096.
  - FIXED with len > 15.
- len=0 means a single beat with beat_last=1 at index 0.
- Reset asserted mid-burst aborts the burst immediately: outputs return to reset values and no residual beats are emitted.

Test Plan (DATA_WIDTH_P=32, ADDR_WIDTH_P=32 unless noted):
1. INCR, addr 0x1002, len 3, size 4B, beat_ready=1 → addrs 0x1002, 0x1004, 0x1008, 0x100C; strb 1100, 1111, 1111, 1111; beat_last only on index 3; resp OKAY; first beat_valid one cycle after accept.
2. WRAP, addr 0x0034, len 3, size 4B → addrs 0x34, 0x38, 0x3C, 0x30; strb 1111 on all beats. Separately, WRAP len 2 → resp SLVERR on all 3 beats.
3. FIXED, addr 0x0101, len 2, size 1B → addr 0x101 ×3, strb 0010 ×3. Then INCR, addr 0x0102, len 1, size 2B → 0x102/strb 1100, then 0x104/strb 0011.
4. INCR, addr 0x0FF8, len 3, size 4B (crosses 4 KB) → 4 beats, resp SLVERR each. Then size 8B on the 32-bit bus → SLVERR, strb 1111.
5. Back-to-back and backpressure:
   - beat_ready=0 for 3 cycles at index 1 → all beat outputs stable.
   - Second command held valid → cmd_ready=1 only in the last-beat handshake cycle; new beat 0 on the next cycle; no idle gap.
6. rst_n low during index 2 of a len 7 burst → beat_valid=0 asynchronously. After release, cmd_ready=1, and a new len 0 command yields one beat with beat_last=1.
